// File: rtl/ttt_strategy_fsm.sv
// Tic-tac-toe opponent: tracks both players' boards, validates human moves and
// answers with a priority strategy (win, block, centre, corner, edge).
module ttt_strategy_fsm #(
  parameter int                MOVE_W     = 4,
  parameter logic [MOVE_W-1:0] NO_MOVE    = {MOVE_W{1'b1}},
  parameter bit                COMP_FIRST = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [MOVE_W-1:0] hMove,
  output logic [MOVE_W-1:0] cMove,
  output logic              win,
  output logic              hWin,
  output logic              draw,
  output logic              illegal,
  output logic              hTurn
);

  typedef enum logic [2:0] {WAIT_H, THINK, C_WIN, H_WIN, DRAW} state_t;

  // One 9-bit square mask per line; bit i stands for square i+1.
  localparam logic [71:0] LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                   9'h049, 9'h1C0, 9'h038, 9'h007};
  localparam logic [8:0]  CENTRE  = 9'h010;
  localparam logic [8:0]  CORNERS = 9'h145;
  localparam logic [8:0]  EDGES   = 9'h0AA;
  localparam logic [8:0]  ALL_SQ  = 9'h1FF;

  state_t            state_q, state_d;
  logic [8:0]        h_board_q, h_board_d;
  logic [8:0]        c_board_q, c_board_d;
  logic [MOVE_W-1:0] cmove_q, cmove_d;
  logic              win_q, win_d;
  logic              hwin_q, hwin_d;
  logic              draw_q, draw_d;
  logic              illegal_q, illegal_d;
  logic              hturn_q, hturn_d;

  logic [8:0]        occ, empty;
  logic [8:0]        hm_hot;
  logic              hm_legal;
  logic [7:0]        h_line;
  logic [7:0]        c_line_new;
  logic [8:0]        c_comp_m [8];
  logic [8:0]        h_block_m [8];
  logic [8:0]        win_cand, block_cand;
  logic [8:0]        pick_mask, pick_hot, c_new;
  logic [MOVE_W-1:0] pick_sq;

  assign occ   = h_board_q | c_board_q;
  assign empty = ~occ;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_decode
      assign hm_hot[gi] = (hMove == MOVE_W'(gi + 1));
    end

    for (gi = 0; gi < 8; gi++) begin : g_line
      localparam logic [8:0] M = LINES[gi*9 +: 9];
      assign h_line[gi]     = ((h_board_q & M) == M);
      assign c_line_new[gi] = ((c_new & M) == M);
      // A line with two of one player's marks and none of the other's has
      // exactly one empty square, which is the completing/blocking square.
      assign c_comp_m[gi]  = (($countones(c_board_q & M) == 2) && ((h_board_q & M) == 9'd0))
                             ? (M & ~c_board_q) : 9'd0;
      assign h_block_m[gi] = (($countones(h_board_q & M) == 2) && ((c_board_q & M) == 9'd0))
                             ? (M & ~h_board_q) : 9'd0;
    end
  endgenerate

  assign hm_legal = (|hm_hot) && ((hm_hot & occ) == 9'd0);

  always_comb begin
    win_cand   = 9'd0;
    block_cand = 9'd0;
    for (int l = 0; l < 8; l++) begin
      win_cand   = win_cand | c_comp_m[l];
      block_cand = block_cand | h_block_m[l];
    end
  end

  always_comb begin
    pick_mask = 9'd0;
    if (|win_cand)                   pick_mask = win_cand;
    else if (|block_cand)            pick_mask = block_cand;
    else if (|(empty & CENTRE))      pick_mask = CENTRE;
    else if (|(empty & CORNERS))     pick_mask = empty & CORNERS;
    else                             pick_mask = empty & EDGES;
  end

  // Isolating the lowest set bit resolves ties towards the lowest square.
  assign pick_hot = pick_mask & (~pick_mask + 9'd1);
  assign c_new    = c_board_q | pick_hot;

  always_comb begin
    pick_sq = '0;
    for (int i = 0; i < 9; i++) begin
      if (pick_hot[i]) pick_sq = MOVE_W'(i + 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    h_board_d = h_board_q;
    c_board_d = c_board_q;
    cmove_d   = cmove_q;
    win_d     = win_q;
    hwin_d    = hwin_q;
    draw_d    = draw_q;
    illegal_d = 1'b0;
    case (state_q)
      WAIT_H: begin
        if (hMove != NO_MOVE) begin
          if (hm_legal) begin
            h_board_d = h_board_q | hm_hot;
            state_d   = THINK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      THINK: begin
        if (|h_line) begin
          state_d = H_WIN;
          hwin_d  = 1'b1;
        end else if (occ == ALL_SQ) begin
          state_d = DRAW;
          draw_d  = 1'b1;
        end else begin
          cmove_d   = pick_sq;
          c_board_d = c_new;
          if (|c_line_new) begin
            state_d = C_WIN;
            win_d   = 1'b1;
          end else if ((h_board_q | c_new) == ALL_SQ) begin
            state_d = DRAW;
            draw_d  = 1'b1;
          end else begin
            state_d = WAIT_H;
          end
        end
      end
      default: ;
    endcase
    hturn_d = (state_d == WAIT_H);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= COMP_FIRST ? THINK : WAIT_H;
      h_board_q <= 9'd0;
      c_board_q <= 9'd0;
      cmove_q   <= NO_MOVE;
      win_q     <= 1'b0;
      hwin_q    <= 1'b0;
      draw_q    <= 1'b0;
      illegal_q <= 1'b0;
      hturn_q   <= ~COMP_FIRST;
    end else begin
      state_q   <= state_d;
      h_board_q <= h_board_d;
      c_board_q <= c_board_d;
      cmove_q   <= cmove_d;
      win_q     <= win_d;
      hwin_q    <= hwin_d;
      draw_q    <= draw_d;
      illegal_q <= illegal_d;
      hturn_q   <= hturn_d;
    end
  end

  assign cMove   = cmove_q;
  assign win     = win_q;
  assign hWin    = hwin_q;
  assign draw    = draw_q;
  assign illegal = illegal_q;
  assign hTurn   = hturn_q;

endmodule
